// File: rtl/decode_pkg.sv
// Shared types and constants for the fetch/decode boundary: the queued fetch
// entry layout, the NOP bubble and the RISC-V field positions.
package decode_pkg;

    localparam int DF_ADDR_W  = 64;
    localparam int DF_INSTR_W = 32;
    localparam int DF_REG_W   = 5;
    localparam int DF_BTB_W   = 2;

    // addi x0, x0, 0 -- the canonical bubble presented when nothing is queued
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OP_LSB    = 0;
    localparam int OP_W      = 7;
    localparam int RD_LSB    = 7;
    localparam int FUNC3_LSB = 12;
    localparam int FUNC3_W   = 3;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;

    typedef struct packed {
        logic [DF_INSTR_W-1:0] instruction;
        logic [DF_ADDR_W-1:0]  pc;
        logic [DF_ADDR_W-1:0]  pc_plus4;
        logic [DF_ADDR_W-1:0]  pc_target_pred;
        logic [DF_BTB_W-1:0]   btb_way;
        logic                  branch_pred_taken;
    } fetch_entry_t;

endpackage

// File: rtl/decode_field_extract.sv
// Pure combinational slicing of opcode, func3 and register addresses out of an
// instruction word; shared between the fetch queue head and the decode stage.
module decode_field_extract
    import decode_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int REG_ADDR_W  = 5
) (
    input  logic [INSTR_WIDTH-1:0] instr_i,
    output logic [OP_W-1:0]        op_o,
    output logic [FUNC3_W-1:0]     func3_o,
    output logic [REG_ADDR_W-1:0]  rs1_addr_o,
    output logic [REG_ADDR_W-1:0]  rs2_addr_o,
    output logic [REG_ADDR_W-1:0]  rd_addr_o
);

    assign op_o       = instr_i[OP_LSB +: OP_W];
    assign func3_o    = instr_i[FUNC3_LSB +: FUNC3_W];
    assign rs1_addr_o = instr_i[RS1_LSB +: REG_ADDR_W];
    assign rs2_addr_o = instr_i[RS2_LSB +: REG_ADDR_W];
    assign rd_addr_o  = instr_i[RD_LSB +: REG_ADDR_W];

    // funct7 and any wider upper bits are decoded elsewhere
    logic unused_upper_bits;
    assign unused_upper_bits = ^instr_i[INSTR_WIDTH-1:RS2_LSB+REG_ADDR_W];

endmodule

// File: rtl/decode_fetch_queue.sv
// DEPTH-entry queue between fetch and decode with valid/ready on both sides,
// single-cycle flush, and a NOP bubble presented at the head when empty.
module decode_fetch_queue
    import decode_pkg::*;
#(
    parameter int ADDR_WIDTH  = DF_ADDR_W,
    parameter int INSTR_WIDTH = DF_INSTR_W,
    parameter int REG_ADDR_W  = DF_REG_W,
    parameter int BTB_WAY_W   = DF_BTB_W,
    parameter int DEPTH       = 4
) (
    input  logic                         i_clk,
    input  logic                         i_arst,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [INSTR_WIDTH-1:0]       i_instruction,
    input  logic [ADDR_WIDTH-1:0]        i_pc,
    input  logic [ADDR_WIDTH-1:0]        i_pc_plus4,
    input  logic [ADDR_WIDTH-1:0]        i_pc_target_pred,
    input  logic [BTB_WAY_W-1:0]         i_btb_way,
    input  logic                         i_branch_pred_taken,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [INSTR_WIDTH-1:0]       o_instruction,
    output logic [ADDR_WIDTH-1:0]        o_pc,
    output logic [ADDR_WIDTH-1:0]        o_pc_plus4,
    output logic [ADDR_WIDTH-1:0]        o_pc_target_pred,
    output logic [BTB_WAY_W-1:0]         o_btb_way,
    output logic                         o_branch_pred_taken,
    output logic [6:0]                   o_op,
    output logic [2:0]                   o_func3,
    output logic [REG_ADDR_W-1:0]        o_rs1_addr,
    output logic [REG_ADDR_W-1:0]        o_rs2_addr,
    output logic [REG_ADDR_W-1:0]        o_rd_addr,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    // ready depends only on the count register, never on the consumer's i_ready
    assign o_ready = (count_q != CNT_W'(DEPTH));
    assign o_valid = (count_q != '0);

    assign push = i_valid && o_ready && !i_flush;
    assign pop  = o_valid && i_ready && !i_flush;

    always_comb begin
        wr_entry                   = '0;
        wr_entry.instruction       = i_instruction;
        wr_entry.pc                = i_pc;
        wr_entry.pc_plus4          = i_pc_plus4;
        wr_entry.pc_target_pred    = i_pc_target_pred;
        wr_entry.btb_way           = i_btb_way;
        wr_entry.branch_pred_taken = i_branch_pred_taken;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; validity comes solely from the count.
    always_ff @(posedge i_clk) begin
        if (push && !i_arst) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_comb begin
        head             = '0;
        head.instruction = NOP_INSTR;
        if (o_valid) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign o_instruction       = head.instruction;
    assign o_pc                = head.pc;
    assign o_pc_plus4          = head.pc_plus4;
    assign o_pc_target_pred    = head.pc_target_pred;
    assign o_btb_way           = head.btb_way;
    assign o_branch_pred_taken = head.branch_pred_taken;

    assign o_count       = count_q;
    assign o_almost_full = (count_q >= CNT_W'(DEPTH-1));

    decode_field_extract #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .REG_ADDR_W  (REG_ADDR_W)
    ) u_field_extract (
        .instr_i    (head.instruction),
        .op_o       (o_op),
        .func3_o    (o_func3),
        .rs1_addr_o (o_rs1_addr),
        .rs2_addr_o (o_rs2_addr),
        .rd_addr_o  (o_rd_addr)
    );

endmodule

// File: tb/tb_decode_fetch_queue.sv
// Self-checking bench for decode_fetch_queue: vector table plus hand-written
// flush/reset/wrap sequences, all checked against a queue-based model.
module tb_decode_fetch_queue;
    import decode_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        arst, flush, valid, ready;
    logic [31:0] instr;
    logic [63:0] pc, pc4, tgt;
    logic [1:0]  way;
    logic        taken;
    logic        o_ready, o_valid, o_branch_pred_taken, o_almost_full;
    logic [31:0] o_instruction;
    logic [63:0] o_pc, o_pc_plus4, o_pc_target_pred;
    logic [1:0]  o_btb_way;
    logic [6:0]  o_op;
    logic [2:0]  o_func3;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
    logic [2:0]  o_count;

    always #5 clk = ~clk;

    decode_fetch_queue #(.DEPTH(DEPTH)) dut (
        .i_clk               (clk),
        .i_arst              (arst),
        .i_flush             (flush),
        .i_valid             (valid),
        .o_ready             (o_ready),
        .i_instruction       (instr),
        .i_pc                (pc),
        .i_pc_plus4          (pc4),
        .i_pc_target_pred    (tgt),
        .i_btb_way           (way),
        .i_branch_pred_taken (taken),
        .o_valid             (o_valid),
        .i_ready             (ready),
        .o_instruction       (o_instruction),
        .o_pc                (o_pc),
        .o_pc_plus4          (o_pc_plus4),
        .o_pc_target_pred    (o_pc_target_pred),
        .o_btb_way           (o_btb_way),
        .o_branch_pred_taken (o_branch_pred_taken),
        .o_op                (o_op),
        .o_func3             (o_func3),
        .o_rs1_addr          (o_rs1_addr),
        .o_rs2_addr          (o_rs2_addr),
        .o_rd_addr           (o_rd_addr),
        .o_count             (o_count),
        .o_almost_full       (o_almost_full)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] pc4;
        logic [63:0] tgt;
        logic [1:0]  way;
        logic        tk;
    } ent_t;

    typedef struct {
        bit          arst;
        bit          flush;
        bit          valid;
        bit          ready;
        logic [63:0] pc;
        int          ecount;
        bit          evalid;
        bit          eready;
        bit          eaf;
    } vec_t;

    ent_t model_q[$];
    vec_t vecs[11];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   checks_en = 0;

    function automatic logic [31:0] mk_instr(input logic [63:0] p);
        logic [31:0] r;
        r = {p[24:0], 7'h33};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit a, input bit f, input bit v, input bit r,
                         input logic [63:0] p, input logic [31:0] ins);
        arst  = a;
        flush = f;
        valid = v;
        ready = r;
        pc    = p;
        instr = ins;
        pc4   = p + 64'd4;
        tgt   = p + 64'h100;
        way   = p[3:2];
        taken = p[2];
    endtask

    // Checks current outputs against the model, advances the model by what
    // the driven inputs should do on the coming edge, then crosses the edge.
    task automatic tick();
        ent_t e;
        bit   full;
        int   sz;
        sz = model_q.size();
        if (checks_en) begin
            chk("count", 64'(o_count), 64'(sz));
            chk("valid", 64'(o_valid), 64'(sz != 0));
            chk("ready", 64'(o_ready), 64'(sz != DEPTH));
            chk("almost_full", 64'(o_almost_full), 64'(sz >= DEPTH-1));
            if (sz != 0) begin
                e = model_q[0];
                chk("head_pc", o_pc, e.pc);
                chk("head_instr", 64'(o_instruction), 64'(e.instr));
                chk("head_pc4", o_pc_plus4, e.pc4);
                chk("head_tgt", o_pc_target_pred, e.tgt);
                chk("head_meta", 64'({o_btb_way, o_branch_pred_taken}), 64'({e.way, e.tk}));
                chk("head_fields", 64'({o_op, o_func3, o_rs1_addr, o_rs2_addr, o_rd_addr}),
                    64'({e.instr[6:0], e.instr[14:12], e.instr[19:15], e.instr[24:20], e.instr[11:7]}));
            end else begin
                chk("bubble_instr", 64'(o_instruction), 64'h13);
                chk("bubble_payload", o_pc | o_pc_plus4 | o_pc_target_pred
                    | 64'({o_btb_way, o_branch_pred_taken}), 64'h0);
                chk("bubble_fields", 64'({o_op, o_func3, o_rs1_addr, o_rs2_addr, o_rd_addr}),
                    64'({7'h13, 3'd0, 5'd0, 5'd0, 5'd0}));
            end
        end
        if (arst || flush) begin
            model_q.delete();
        end else begin
            full = (sz == DEPTH);
            if (ready && sz != 0) begin
                $display("pop  pc=%h instr=%h count=%0d", model_q[0].pc, model_q[0].instr, sz);
                void'(model_q.pop_front());
            end
            if (valid && !full) begin
                e.pc = pc; e.instr = instr; e.pc4 = pc4; e.tgt = tgt; e.way = way; e.tk = taken;
                model_q.push_back(e);
                $display("push pc=%h instr=%h", pc, instr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1, 0, 0, 0, 64'h0,    0, 0, 1, 0};
        vecs[1]  = '{0, 0, 0, 0, 64'h0,    0, 0, 1, 0};
        vecs[2]  = '{0, 0, 1, 0, 64'h1000, 1, 1, 1, 0};
        vecs[3]  = '{0, 0, 1, 0, 64'h1004, 2, 1, 1, 0};
        vecs[4]  = '{0, 0, 1, 0, 64'h1008, 3, 1, 1, 1};
        vecs[5]  = '{0, 0, 1, 0, 64'h100C, 4, 1, 0, 1};
        vecs[6]  = '{0, 0, 1, 0, 64'h1010, 4, 1, 0, 1};
        vecs[7]  = '{0, 0, 0, 1, 64'h0,    3, 1, 1, 1};
        vecs[8]  = '{0, 0, 0, 1, 64'h0,    2, 1, 1, 0};
        vecs[9]  = '{0, 0, 0, 1, 64'h0,    1, 1, 1, 0};
        vecs[10] = '{0, 0, 0, 1, 64'h0,    0, 0, 1, 0};

        drive(1, 0, 0, 0, 64'h0, 32'h0);
        @(posedge clk);
        #1;
        checks_en = 1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].arst, vecs[i].flush, vecs[i].valid, vecs[i].ready,
                  vecs[i].pc, mk_instr(vecs[i].pc));
            tick();
            chk("vec_count", 64'(o_count), 64'(vecs[i].ecount));
            chk("vec_flags", 64'({o_valid, o_ready, o_almost_full}),
                64'({vecs[i].evalid, vecs[i].eready, vecs[i].eaf}));
        end
        chk("reset_idle_instr", 64'(o_instruction), 64'h13);

        // Continuous push and pop across the pointer wrap
        drive(0, 0, 1, 0, 64'h6000, mk_instr(64'h6000));
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 1, 64'h6004 + 64'(4 * i), mk_instr(64'h6004 + 64'(4 * i)));
            tick();
            chk("stream_count", 64'(o_count), 64'd1);
        end
        drive(0, 0, 0, 1, 64'h0, 32'h0);
        tick();
        tick();

        // Flush with a same-cycle push and pop
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 64'h3000 + 64'(4 * i), mk_instr(64'h3000 + 64'(4 * i)));
            tick();
        end
        drive(0, 1, 1, 1, 64'h2000, mk_instr(64'h2000));
        tick();
        chk("flush_state", 64'({o_count, o_valid, o_ready}), 64'({3'd0, 1'b0, 1'b1}));
        drive(0, 0, 0, 1, 64'h0, 32'h0);
        tick();
        tick();

        // Field extraction of add x10, x5, x10
        drive(0, 0, 1, 0, 64'h4000, 32'h00A28533);
        tick();
        chk("add_op", 64'(o_op), 64'h33);
        chk("add_func3", 64'(o_func3), 64'h0);
        chk("add_regs", 64'({o_rs1_addr, o_rs2_addr, o_rd_addr}), 64'({5'd5, 5'd10, 5'd10}));
        drive(0, 0, 0, 1, 64'h0, 32'h0);
        tick();

        // Reset with two entries queued and a push pending
        drive(0, 0, 1, 0, 64'h5000, mk_instr(64'h5000));
        tick();
        drive(0, 0, 1, 0, 64'h5004, mk_instr(64'h5004));
        tick();
        drive(1, 0, 1, 1, 64'h5008, mk_instr(64'h5008));
        tick();
        chk("rst_state", 64'({o_count, o_valid, o_ready, o_almost_full}),
            64'({3'd0, 1'b0, 1'b1, 1'b0}));
        chk("rst_instr", 64'(o_instruction), 64'h13);
        chk("rst_pc", o_pc, 64'h0);
        drive(0, 0, 0, 1, 64'h0, 32'h0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_fetch_queue.md
Name: decode_fetch_queue

Overview:
- Parametrised DEPTH-entry instruction queue between the fetch stage and the decode stage.
- Decouples fetch from decode with a valid/ready handshake on both sides.
- Carries each instruction's PC, PC+4 and branch-prediction metadata.
- Presents the head entry with pre-extracted register and opcode fields; supports a single-cycle flush on branch mispredict.

Parameters:
ADDR_WIDTH, 64, width of the PC, PC+4 and predicted-target fields
INSTR_WIDTH, 32, instruction width
REG_ADDR_W, 5, register address width
BTB_WAY_W, 2, width of the BTB way index
DEPTH, 4, number of entries; power of two, at least 2

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_arst  in  1  reset, synchronous, active-high
i_flush  in  1  discard all queued entries
i_valid  in  1  fetch presents an entry
o_ready  out  1  queue can accept an entry (not full)
i_instruction  in  INSTR_WIDTH  fetched instruction
i_pc  in  ADDR_WIDTH  instruction PC
i_pc_plus4  in  ADDR_WIDTH  PC+4
i_pc_target_pred  in  ADDR_WIDTH  predicted target
i_btb_way  in  BTB_WAY_W  BTB hit way
i_branch_pred_taken  in  1  prediction taken
o_valid  out  1  head entry valid
i_ready  in  1  decode accepts the head (decode not stalled)
o_instruction  out  INSTR_WIDTH  head instruction; NOP when empty
o_pc, o_pc_plus4, o_pc_target_pred  out  ADDR_WIDTH each  head fields
o_btb_way  out  BTB_WAY_W  head field
o_branch_pred_taken  out  1  head field
o_op  out  7  head instruction[6:0]
o_func3  out  3  head instruction[14:12]
o_rs1_addr, o_rs2_addr, o_rd_addr  out  REG_ADDR_W each  head instruction [19:15], [24:20], [11:7]
o_count  out  $clog2(DEPTH+1)  current occupancy
o_almost_full  out  1  occupancy is at least DEPTH-1

Behaviour:
- Reset (i_clk edge with i_arst=1): write pointer, read pointer and count go to 0; storage is not cleared.
  - Outputs after reset: o_valid=0, o_ready=1, o_count=0, o_almost_full=0.
  - Payload outputs read as the NOP bubble (see "Empty queue").
- Push occurs when i_valid && o_ready. The entry is written at the write pointer, which then increments modulo DEPTH.
- Pop occurs when o_valid && i_ready. The read pointer increments modulo DEPTH.
- Outputs:
  - o_ready = (count != DEPTH), taken from registered state only; there is no combinational path from i_ready to o_ready.
  - o_valid = (count != 0).
- Simultaneous push and pop (only possible when not full) leaves count unchanged; both pointers advance.
- Full queue: o_ready=0 and any i_valid is ignored, even if a pop happens in the same cycle. Full-cycle throughput is therefore DEPTH-1 entries in steady state with a stalled consumer.
- Empty queue:
  - o_valid=0; a push becomes visible at the head the next cycle (1-cycle latency, no bypass).
  - Head outputs are a bubble: o_instruction = NOP_INSTR (32'h0000_0013), every other payload output = 0, and extracted fields derive from NOP_INSTR.
- Head outputs are read combinationally from the entry at the read pointer, masked by o_valid.
- Flush has priority over push and pop in the same cycle.
  - Both pointers and the count return to 0, and the same-cycle push is dropped.
  - Next cycle: o_valid=0, o_ready=1.
- Reset has priority over flush.
- Reset or flush mid-operation abandons all entries; there is no partial drain.
- Pointer width is $clog2(DEPTH). The count is kept separately, so full and empty are unambiguous.
- o_count and o_almost_full are driven from the count register.

Decomposition:
- Shared package decode_pkg holds:
  - NOP_INSTR constant.
  - fetch_entry_t packed struct {instruction, pc, pc_plus4, pc_target_pred, btb_way, branch_pred_taken}.
  - Field-position constants (OP_LSB, RS1_LSB, RS2_LSB, RD_LSB, FUNC3_LSB).
- One sub-module, decode_field_extract: combinational, takes the head instruction and produces o_op, o_func3 and the rs1/rs2/rd addresses. It is reused by decode_stage.
- Storage array and pointer logic are inline.

Test Plan:
- Reset, then idle -> o_valid=0, o_ready=1, o_count=0, o_instruction=32'h00000013, o_pc=0.
- Push 4 entries (pc 0x1000, 0x1004, 0x1008, 0x100C) with i_ready=0 -> o_count=4, o_ready=0, o_almost_full=1 from count 3; a 5th push (pc 0x1010) is dropped.
- Then set i_ready=1 -> entries pop in order 0x1000 to 0x100C on consecutive cycles, and o_valid drops after the 4th pop.
- Continuous push and pop with DEPTH=4 for 10 cycles -> o_count holds at 1; output order matches input order across the pointer wrap.
- Load 3 entries, then assert i_flush together with i_valid (pc 0x2000) and i_ready=1 -> next cycle o_count=0, o_valid=0, and 0x2000 is never output.
- Head instruction 32'h00A28533 (add x10,x5,x10) -> o_op=7'h33, o_func3=0, o_rs1_addr=5, o_rs2_addr=10, o_rd_addr=10.
- Assert i_arst while 2 entries are queued -> the next cycle matches the reset state.
